// File: rtl/info_packet_state_pkg.sv
// Shared HDMI auxiliary-packet definitions: slot selection encoding and the
// priority pick used by the packet scheduler and the data encoder.
package info_packet_state_pkg;

    typedef logic [1:0] pkt_sel_t;

    localparam pkt_sel_t SEL_NONE  = 2'd0;
    localparam pkt_sel_t SEL_REGEN = 2'd1;
    localparam pkt_sel_t SEL_AVI   = 2'd2;
    localparam pkt_sel_t SEL_AINFO = 2'd3;

    // Clock regeneration outranks the infoframes: sinks lose audio lock fastest.
    function automatic pkt_sel_t pick_sel(input logic regen, input logic avi, input logic ainfo);
        if (regen)      return SEL_REGEN;
        else if (avi)   return SEL_AVI;
        else if (ainfo) return SEL_AINFO;
        else            return SEL_NONE;
    endfunction

endpackage

// File: rtl/info_packet_state.sv
// Chooses which auxiliary packet the data-island encoder loads next and holds
// that choice until the encoder reports it transmitted.
module info_packet_state
    import info_packet_state_pkg::*;
(
    input  logic i_pixclk,
    input  logic i_reset,
    input  logic i_start_of_frame,
    input  logic i_audio_regen_needed,
    input  logic i_packet_sent,
    output logic o_audio_regen,
    output logic o_audio_info,
    output logic o_video_info,
    output logic o_packet_needed
);

    logic     regen_p;
    logic     avi_p;
    logic     ainfo_p;
    pkt_sel_t sel;

    logic done_regen;
    logic done_avi;
    logic done_ainfo;

    assign done_regen = i_packet_sent && (sel == SEL_REGEN);
    assign done_avi   = i_packet_sent && (sel == SEL_AVI);
    assign done_ainfo = i_packet_sent && (sel == SEL_AINFO);

    // A new request in the same cycle as completion keeps the flag set, so the
    // type is served again rather than silently dropped.
    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            regen_p <= 1'b0;
            avi_p   <= 1'b0;
            ainfo_p <= 1'b0;
            sel     <= SEL_NONE;
        end else begin
            regen_p <= i_audio_regen_needed | (regen_p & ~done_regen);
            avi_p   <= i_start_of_frame     | (avi_p   & ~done_avi);
            ainfo_p <= i_start_of_frame     | (ainfo_p & ~done_ainfo);
            if (sel == SEL_NONE)
                sel <= pick_sel(regen_p, avi_p, ainfo_p);
            else if (i_packet_sent)
                sel <= SEL_NONE;
        end
    end

    assign o_audio_regen   = (sel == SEL_REGEN);
    assign o_video_info    = (sel == SEL_AVI);
    assign o_audio_info    = (sel == SEL_AINFO);
    assign o_packet_needed = (sel != SEL_NONE);

endmodule

// File: tb/tb_info_packet_state.sv
// Directed bench for the auxiliary packet scheduler: a vector table plus a few
// hand-written multi-cycle sequences.
module tb_info_packet_state;

    logic clk = 1'b0;
    logic rst, sof, regen, sent;
    logic o_audio_regen, o_audio_info, o_video_info, o_packet_needed;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected output nibble: {audio_regen, audio_info, video_info, packet_needed}
    localparam logic [3:0] E_NONE  = 4'b0000;
    localparam logic [3:0] E_REGEN = 4'b1001;
    localparam logic [3:0] E_AINFO = 4'b0101;
    localparam logic [3:0] E_VIDEO = 4'b0011;

    typedef struct {
        logic       rst;
        logic       sof;
        logic       regen;
        logic       sent;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[29];

    info_packet_state dut (
        .i_pixclk             (clk),
        .i_reset              (rst),
        .i_start_of_frame     (sof),
        .i_audio_regen_needed (regen),
        .i_packet_sent        (sent),
        .o_audio_regen        (o_audio_regen),
        .o_audio_info         (o_audio_info),
        .o_video_info         (o_video_info),
        .o_packet_needed      (o_packet_needed)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic s, input logic g, input logic d,
                                input logic [3:0] e);
        vec_t v;
        v.rst = r; v.sof = s; v.regen = g; v.sent = d; v.exp = e;
        return v;
    endfunction

    // Drive one cycle of inputs, then check outputs just after the edge.
    task automatic step(input logic r, input logic s, input logic g, input logic d,
                        input logic [3:0] e, input string name);
        logic [3:0] act;
        @(negedge clk);
        rst = r; sof = s; regen = g; sent = d;
        @(posedge clk);
        #1;
        act = {o_audio_regen, o_audio_info, o_video_info, o_packet_needed};
        n_checks++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s: outputs(regen,ainfo,video,needed)=%b expected %b", name, act, e);
        end
        n_checks++;
        if (!$onehot0({o_audio_regen, o_audio_info, o_video_info}) ||
            (o_packet_needed !== (o_audio_regen | o_audio_info | o_video_info))) begin
            n_fail++;
            $display("FAIL %s_onehot: selects=%b needed=%b expected one-hot/zero with needed=OR",
                     name, {o_audio_regen, o_audio_info, o_video_info}, o_packet_needed);
        end
    endtask

    initial begin
        rst = 1'b1; sof = 1'b0; regen = 1'b0; sent = 1'b0;

        // reset held two cycles with every input pulsing
        tbl[0]  = mk(1, 1, 1, 1, E_NONE);
        tbl[1]  = mk(1, 1, 1, 1, E_NONE);
        tbl[2]  = mk(0, 0, 0, 0, E_NONE);
        tbl[3]  = mk(0, 0, 0, 0, E_NONE);
        // frame start: AVI, idle, audio infoframe
        tbl[4]  = mk(0, 1, 0, 0, E_NONE);
        tbl[5]  = mk(0, 0, 0, 0, E_VIDEO);
        tbl[6]  = mk(0, 0, 0, 1, E_NONE);
        tbl[7]  = mk(0, 0, 0, 0, E_AINFO);
        tbl[8]  = mk(0, 0, 0, 1, E_NONE);
        tbl[9]  = mk(0, 0, 0, 0, E_NONE);
        // hold AVI against three coalesced regen requests
        tbl[10] = mk(0, 1, 0, 0, E_NONE);
        tbl[11] = mk(0, 0, 0, 0, E_VIDEO);
        tbl[12] = mk(0, 0, 1, 0, E_VIDEO);
        tbl[13] = mk(0, 0, 1, 0, E_VIDEO);
        tbl[14] = mk(0, 0, 1, 0, E_VIDEO);
        tbl[15] = mk(0, 0, 0, 1, E_NONE);
        tbl[16] = mk(0, 0, 0, 0, E_REGEN);
        tbl[17] = mk(0, 0, 0, 1, E_NONE);
        tbl[18] = mk(0, 0, 0, 0, E_AINFO);
        tbl[19] = mk(0, 0, 0, 1, E_NONE);
        tbl[20] = mk(0, 0, 0, 0, E_NONE);
        // stray sent with nothing pending
        tbl[21] = mk(0, 0, 0, 1, E_NONE);
        tbl[22] = mk(0, 0, 0, 0, E_NONE);
        // regen request colliding with its own completion
        tbl[23] = mk(0, 0, 1, 0, E_NONE);
        tbl[24] = mk(0, 0, 0, 0, E_REGEN);
        tbl[25] = mk(0, 0, 1, 1, E_NONE);
        tbl[26] = mk(0, 0, 0, 0, E_REGEN);
        tbl[27] = mk(0, 0, 0, 1, E_NONE);
        tbl[28] = mk(0, 0, 0, 0, E_NONE);

        for (int i = 0; i < 29; i++)
            step(tbl[i].rst, tbl[i].sof, tbl[i].regen, tbl[i].sent, tbl[i].exp,
                 $sformatf("vec%0d", i));

        // simultaneous frame start + regen: full priority order
        step(0, 1, 1, 0, E_NONE,  "prio_req");
        step(0, 0, 0, 0, E_REGEN, "prio_regen");
        step(0, 0, 0, 1, E_NONE,  "prio_gap1");
        step(0, 0, 0, 0, E_VIDEO, "prio_avi");
        step(0, 0, 0, 1, E_NONE,  "prio_gap2");
        step(0, 0, 0, 0, E_AINFO, "prio_ainfo");
        step(0, 0, 0, 1, E_NONE,  "prio_done");

        // sent while idle but with requests pending is ignored
        step(0, 1, 0, 0, E_NONE,  "idle_req");
        step(0, 0, 0, 1, E_VIDEO, "idle_sent_ignored");
        step(0, 0, 0, 1, E_NONE,  "idle_avi_done");
        step(0, 0, 0, 0, E_AINFO, "idle_ainfo");

        // request arriving with a completion still waits for the idle cycle
        step(0, 0, 1, 1, E_NONE,  "late_req");
        step(0, 0, 0, 0, E_REGEN, "late_regen");

        // reset mid-operation drops the selection and pending requests
        step(0, 1, 0, 0, E_REGEN, "mid_req");
        step(1, 1, 1, 0, E_NONE,  "mid_reset");
        step(0, 0, 0, 0, E_NONE,  "mid_after1");
        step(0, 0, 0, 0, E_NONE,  "mid_after2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
